// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer
//   Multi-cycle control stage in front of the 8-entry register file
//   (T1-T4, R1-R4). Accepts 16-bit micro-ops over valid/ready and steps
//   each one through the file's I / O1Sel / FunSel / RSel / TSel controls.
//
//   Optional feature macro: RFSEQ_SWAP_EN
//     defined   -> opcode 7 executes SWAP (RDL -> MV -> WR)
//     undefined -> MV state not built, opcode 7 is illegal
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   op_valid/op_ready   micro-op handshake; op[15:12] opcode, [11:9] dst,
//                       [8:6] src, [7:0] immediate
//   rf_i, rf_o1sel,     register file controls
//   rf_funsel, rf_rsel,
//   rf_tsel
//   rf_o1               register file combinational read port
//   res_valid/res_data  one-cycle result pulse for RD
//   err                 one-cycle pulse after accepting an illegal opcode
module rf_op_sequencer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [15:0]   op,
    output logic [DW-1:0] rf_i,
    output logic [2:0]    rf_o1sel,
    output logic [1:0]    rf_funsel,
    output logic [3:0]    rf_rsel,
    output logic [3:0]    rf_tsel,
    input  logic [DW-1:0] rf_o1,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic          err
);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_CLR  = 4'd2;
    localparam logic [3:0] OP_INC  = 4'd3;
    localparam logic [3:0] OP_DEC  = 4'd4;
    localparam logic [3:0] OP_MOV  = 4'd5;
    localparam logic [3:0] OP_RD   = 4'd6;
    localparam logic [3:0] OP_SWAP = 4'd7;

    localparam logic [1:0] FS_CLR  = 2'b00;
    localparam logic [1:0] FS_LOAD = 2'b01;
    localparam logic [1:0] FS_DEC  = 2'b10;
    localparam logic [1:0] FS_INC  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RDL  = 2'd1,
`ifdef RFSEQ_SWAP_EN
        S_MV   = 2'd2,
`endif
        S_WR   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    op_q;
    logic [DW-1:0]  hold_q;
    logic [DW-1:0]  res_data_q;
    logic           res_valid_q;
    logic           err_q;

    logic [3:0]     opc_q;
    logic [2:0]     dst_q, src_q;
    logic           accept;

    assign opc_q  = op_q[15:12];
    assign dst_q  = op_q[11:9];
    assign src_q  = op_q[8:6];
    assign accept = (state_q == S_IDLE) && op_valid;

    // Register code -> {rsel, tsel}; code[2] picks the bank, bit 3-code[1:0]
    // within it is the one-hot enable.
    function automatic logic [7:0] code_en(input logic [2:0] c);
        logic [3:0] oh;
        oh = 4'b1000 >> c[1:0];
        return c[2] ? {oh, 4'b0000} : {4'b0000, oh};
    endfunction

    function automatic logic op_legal(input logic [3:0] opc);
`ifdef RFSEQ_SWAP_EN
        return opc <= OP_SWAP;
`else
        return opc <= OP_RD;
`endif
    endfunction

    // Enables are decoded from the registered state only, so reset takes
    // effect at the edge: a write already in flight in the current cycle
    // (e.g. the SWAP MV step) still lands.
    always_comb begin
        state_d   = state_q;
        rf_i      = '0;
        rf_o1sel  = 3'b000;
        rf_funsel = FS_LOAD;
        rf_rsel   = 4'b0000;
        rf_tsel   = 4'b0000;

        unique case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    case (op[15:12])
                        OP_LDI, OP_CLR, OP_INC, OP_DEC: state_d = S_WR;
                        OP_MOV, OP_RD:                  state_d = S_RDL;
`ifdef RFSEQ_SWAP_EN
                        OP_SWAP:                        state_d = S_RDL;
`endif
                        default:                        state_d = S_IDLE;
                    endcase
                end
            end

            S_RDL: begin
                // SWAP reads dst first; MOV/RD read src
                rf_o1sel = (opc_q == OP_SWAP) ? dst_q : src_q;
                case (opc_q)
                    OP_MOV:  state_d = S_WR;
`ifdef RFSEQ_SWAP_EN
                    OP_SWAP: state_d = S_MV;
`endif
                    default: state_d = S_IDLE;
                endcase
            end

`ifdef RFSEQ_SWAP_EN
            S_MV: begin
                // dst <- src straight through the read port
                rf_o1sel           = src_q;
                rf_i               = rf_o1;
                rf_funsel          = FS_LOAD;
                {rf_rsel, rf_tsel} = code_en(dst_q);
                state_d            = S_WR;
            end
`endif

            S_WR: begin
                {rf_rsel, rf_tsel} = code_en(dst_q);
                case (opc_q)
                    OP_LDI:  begin rf_i = DW'(op_q[7:0]); rf_funsel = FS_LOAD; end
                    OP_CLR:  rf_funsel = FS_CLR;
                    OP_INC:  rf_funsel = FS_INC;
                    OP_DEC:  rf_funsel = FS_DEC;
                    OP_MOV:  begin rf_i = hold_q; rf_funsel = FS_LOAD; end
                    OP_SWAP: begin
                        // old dst (held) goes to src
                        rf_i               = hold_q;
                        rf_funsel          = FS_LOAD;
                        {rf_rsel, rf_tsel} = code_en(src_q);
                    end
                    default: {rf_rsel, rf_tsel} = 8'h00;
                endcase
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            hold_q      <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            if (accept) begin
                op_q  <= op;
                err_q <= !op_legal(op[15:12]);
            end
            if (state_q == S_RDL) begin
                hold_q <= rf_o1;
                if (opc_q == OP_RD) begin
                    res_data_q  <= rf_o1;
                    res_valid_q <= 1'b1;
                end
            end
        end
    end

    assign op_ready  = (state_q == S_IDLE);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
module tb_rf_op_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op;
    logic [7:0]  rf_i;
    logic [2:0]  rf_o1sel;
    logic [1:0]  rf_funsel;
    logic [3:0]  rf_rsel, rf_tsel;
    logic [7:0]  rf_o1;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        err;

    rf_op_sequencer #(.DW(8)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
        .rf_i(rf_i), .rf_o1sel(rf_o1sel), .rf_funsel(rf_funsel),
        .rf_rsel(rf_rsel), .rf_tsel(rf_tsel), .rf_o1(rf_o1),
        .res_valid(res_valid), .res_data(res_data), .err(err)
    );

    always #5 clk = ~clk;

`ifdef RFSEQ_SWAP_EN
    localparam bit SWAP_ON = 1'b1;
`else
    localparam bit SWAP_ON = 1'b0;
`endif

    // Behavioural register file, indexed by register code (0-3 T1-T4, 4-7 R1-R4)
    logic [7:0] rf [8];
    logic       rf_init = 1'b1;
    assign rf_o1 = rf[rf_o1sel];

    function automatic logic [7:0] rf_next(input logic [7:0] v);
        case (rf_funsel)
            2'b00:   return 8'h00;
            2'b01:   return rf_i;
            2'b10:   return v - 8'd1;
            default: return v + 8'd1;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rf_init) begin
                rf[k] <= 8'h00; rf[k+4] <= 8'h00;
            end else begin
                if (rf_tsel[3-k]) rf[k]   <= rf_next(rf[k]);
                if (rf_rsel[3-k]) rf[k+4] <= rf_next(rf[k+4]);
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    // reference state
    logic [7:0] mreg [8];
    int         exp_busy;
    int         exp_err, exp_res;
    logic [7:0] exp_rdat;

    // observations from one op
    int         ob_busy, ob_err, ob_res, ob_en;
    logic [7:0] ob_rdat, ob_i;
    logic [3:0] ob_rsel, ob_tsel;
    logic [1:0] ob_fun;
    bit         ob_tmo;

    // Spec-level semantics of one op on the model registers.
    task automatic model_apply(input logic [15:0] o);
        logic [3:0] opc;
        logic [2:0] d, s;
        logic [7:0] t;
        opc = o[15:12]; d = o[11:9]; s = o[8:6];
        exp_err = 0; exp_res = 0; exp_rdat = 8'h00; exp_busy = 1;
        case (opc)
            4'd0: exp_busy = 1;
            4'd1: begin mreg[d] = o[7:0]; exp_busy = 2; end
            4'd2: begin mreg[d] = 8'h00; exp_busy = 2; end
            4'd3: begin mreg[d] = mreg[d] + 8'd1; exp_busy = 2; end
            4'd4: begin mreg[d] = mreg[d] - 8'd1; exp_busy = 2; end
            4'd5: begin mreg[d] = mreg[s]; exp_busy = 3; end
            4'd6: begin exp_res = 1; exp_rdat = mreg[s]; exp_busy = 2; end
            4'd7: begin
                if (SWAP_ON) begin
                    t = mreg[d]; mreg[d] = mreg[s]; mreg[s] = t; exp_busy = 4;
                end else begin
                    exp_err = 1; exp_busy = 1;
                end
            end
            default: begin exp_err = 1; exp_busy = 1; end
        endcase
    endtask

    // Issue one op (called at a negedge) and record what the DUT does until
    // it is ready again. Returns at a negedge.
    task automatic run_op(input logic [15:0] o);
        int g;
        ob_busy = 0; ob_err = 0; ob_res = 0; ob_en = 0; ob_tmo = 0;
        ob_rdat = 8'h00; ob_i = 8'h00; ob_rsel = 4'h0; ob_tsel = 4'h0; ob_fun = 2'b00;
        model_apply(o);
        op = o; op_valid = 1'b1;
        g = 0;
        while (!op_ready && g < 20) begin @(negedge clk); g++; end
        if (!op_ready) begin ob_tmo = 1; op_valid = 1'b0; return; end
        @(posedge clk); #1;
        op_valid = 1'b0; op = 16'($urandom);
        ob_busy = 1;
        forever begin
            @(negedge clk);
            if ((rf_rsel | rf_tsel) != 4'h0) begin
                ob_en++; ob_rsel = rf_rsel; ob_tsel = rf_tsel; ob_fun = rf_funsel; ob_i = rf_i;
            end
            if (err) ob_err++;
            if (res_valid) begin ob_res++; ob_rdat = res_data; end
            if (op_ready) break;
            ob_busy++;
            if (ob_busy > 10) begin ob_tmo = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; op_valid = 1'b0; op = 16'h0;
        repeat (3) @(posedge clk);
        #1 rf_init = 1'b0;
        for (int k = 0; k < 8; k++) mreg[k] = 8'h00;
        @(negedge clk);
        n_chk++; if ((rf_rsel | rf_tsel) !== 4'h0) begin n_fail++; $display("FAIL reset_en: rsel=%b tsel=%b want 0", rf_rsel, rf_tsel); end
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", op_ready); end
        n_chk++; if ({res_valid, err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: res_valid=%b err=%b want 0", res_valid, err); end
        n_chk++; if ({rf_funsel, rf_o1sel, rf_i} !== {2'b01, 3'b000, 8'h00}) begin
            n_fail++; $display("FAIL reset_idle_drive: fun=%b o1sel=%b i=%h want 01/000/00", rf_funsel, rf_o1sel, rf_i); end
        n_chk++; if (res_data !== 8'h00) begin n_fail++; $display("FAIL reset_res_data: got %h want 00", res_data); end
    endtask

    task automatic test_ldi();
        run_op(16'h1A5E);
        n_chk++; if (ob_tmo || ob_busy !== 2) begin n_fail++; $display("FAIL ldi_busy: got %0d tmo=%0d want 2", ob_busy, ob_tmo); end
        n_chk++; if ({ob_rsel, ob_tsel} !== 8'b0100_0000) begin n_fail++; $display("FAIL ldi_en: rsel=%b tsel=%b want 0100/0000", ob_rsel, ob_tsel); end
        n_chk++; if (ob_fun !== 2'b01 || ob_i !== 8'h5E) begin n_fail++; $display("FAIL ldi_drive: fun=%b i=%h want 01/5e", ob_fun, ob_i); end
        n_chk++; if (rf[5] !== 8'h5E) begin n_fail++; $display("FAIL ldi_r2: got %h want 5e", rf[5]); end
    endtask

    task automatic test_inc_dec_wrap();
        run_op(16'h16FF);
        run_op(16'h3600);
        n_chk++; if (ob_tsel !== 4'b0001 || ob_rsel !== 4'b0000 || ob_fun !== 2'b11) begin
            n_fail++; $display("FAIL inc_drive: tsel=%b rsel=%b fun=%b want 0001/0000/11", ob_tsel, ob_rsel, ob_fun); end
        n_chk++; if (rf[3] !== 8'h00) begin n_fail++; $display("FAIL inc_wrap: got %h want 00", rf[3]); end
        run_op(16'h4600);
        n_chk++; if (ob_fun !== 2'b10) begin n_fail++; $display("FAIL dec_fun: got %b want 10", ob_fun); end
        n_chk++; if (rf[3] !== 8'hFF) begin n_fail++; $display("FAIL dec_wrap: got %h want ff", rf[3]); end
    endtask

    task automatic test_mov_rd();
        run_op(16'h1818);
        run_op(16'h5300);
        n_chk++; if (ob_busy !== 3) begin n_fail++; $display("FAIL mov_busy: got %0d want 3", ob_busy); end
        n_chk++; if (rf[1] !== 8'h18 || rf[4] !== 8'h18) begin n_fail++; $display("FAIL mov_val: t2=%h r1=%h want 18/18", rf[1], rf[4]); end
        run_op(16'h6040);
        n_chk++; if (ob_res !== 1 || ob_rdat !== 8'h18) begin n_fail++; $display("FAIL rd_result: pulses=%0d data=%h want 1/18", ob_res, ob_rdat); end
        n_chk++; if (ob_busy !== 2 || ob_en !== 0) begin n_fail++; $display("FAIL rd_timing: busy=%0d en=%0d want 2/0", ob_busy, ob_en); end
    endtask

    task automatic test_swap();
        run_op(16'h1C11);
        run_op(16'h1022);
        run_op(16'h7C00);
        n_chk++; if (ob_busy !== exp_busy || ob_err !== exp_err) begin
            n_fail++; $display("FAIL swap_timing: busy=%0d err=%0d want %0d/%0d", ob_busy, ob_err, exp_busy, exp_err); end
        n_chk++; if (rf[6] !== mreg[6] || rf[0] !== mreg[0]) begin
            n_fail++; $display("FAIL swap_val: r3=%h t1=%h want %h/%h", rf[6], rf[0], mreg[6], mreg[0]); end
        if (!SWAP_ON) begin
            n_chk++; if (ob_en !== 0) begin n_fail++; $display("FAIL swap_off_en: got %0d enable cycles want 0", ob_en); end
        end
    endtask

    task automatic test_illegal_busy();
        run_op(16'hC123);
        n_chk++; if (ob_err !== 1 || ob_en !== 0 || ob_busy !== 1) begin
            n_fail++; $display("FAIL illegal: err=%0d en=%0d busy=%0d want 1/0/1", ob_err, ob_en, ob_busy); end
        // keep op_valid high across a busy cycle: the INC must be taken once
        op = 16'h1440; op_valid = 1'b1;
        @(posedge clk); #1 op = 16'h3400;
        @(negedge clk);
        n_chk++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b want 0", op_ready); end
        @(negedge clk);
        n_chk++; if (rf[2] !== 8'h40) begin n_fail++; $display("FAIL busy_ignored: t3=%h want 40", rf[2]); end
        @(posedge clk); #1 op_valid = 1'b0;
        repeat (3) @(negedge clk);
        mreg[2] = 8'h41;
        n_chk++; if (rf[2] !== 8'h41) begin n_fail++; $display("FAIL busy_once: t3=%h want 41", rf[2]); end
    endtask

    task automatic test_reset_mid_op();
        run_op(16'h1C11);
        run_op(16'h1022);
        op = SWAP_ON ? 16'h7C00 : 16'h5E00; op_valid = 1'b1;
        @(posedge clk); #1 op_valid = 1'b0;          // now in RDL
        if (SWAP_ON) begin
            @(posedge clk); #1;                       // now in MV
            mreg[6] = 8'h22;                          // MV write lands
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (op_ready !== 1'b1 || (rf_rsel | rf_tsel) !== 4'h0) begin
            n_fail++; $display("FAIL rst_mid_state: ready=%b rsel=%b tsel=%b want 1/0/0", op_ready, rf_rsel, rf_tsel); end
        n_chk++; if ({res_valid, err} !== 2'b00 || res_data !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid_out: res_valid=%b err=%b res_data=%h want 0/0/00", res_valid, err, res_data); end
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (rf[6] !== mreg[6] || rf[0] !== mreg[0] || rf[7] !== mreg[7]) begin
            n_fail++; $display("FAIL rst_mid_regs: r3=%h t1=%h r4=%h want %h/%h/%h", rf[6], rf[0], rf[7], mreg[6], mreg[0], mreg[7]); end
    endtask

    task automatic test_random();
        logic [15:0] o;
        for (int n = 0; n < 150; n++) begin
            o = 16'($urandom);
            o[15:12] = 4'($urandom_range(0, 11));
            run_op(o);
            n_chk++; if (ob_tmo || ob_busy !== exp_busy) begin
                n_fail++; $display("FAIL rand_busy op=%h: got %0d tmo=%0d want %0d", o, ob_busy, ob_tmo, exp_busy); end
            n_chk++; if (ob_err !== exp_err) begin n_fail++; $display("FAIL rand_err op=%h: got %0d want %0d", o, ob_err, exp_err); end
            n_chk++; if (ob_res !== exp_res) begin n_fail++; $display("FAIL rand_res op=%h: got %0d want %0d", o, ob_res, exp_res); end
            if (exp_res == 1) begin
                n_chk++; if (ob_rdat !== exp_rdat) begin n_fail++; $display("FAIL rand_rdat op=%h: got %h want %h", o, ob_rdat, exp_rdat); end
            end
            for (int k = 0; k < 8; k++) begin
                n_chk++; if (rf[k] !== mreg[k]) begin n_fail++; $display("FAIL rand_reg%0d op=%h: got %h want %h", k, o, rf[k], mreg[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_inc_dec_wrap();
        test_mov_rd();
        test_swap();
        test_illegal_busy();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_op_sequencer.md
# rf_op_sequencer

Multi-cycle control stage directly upstream of the 8-register file (T1–T4, R1–R4). It accepts 16-bit register micro-ops over a valid/ready handshake. It sequences each op into the file's `I`, `O1Sel`, `FunSel`, `RSel` and `TSel` controls one cycle at a time. `rf_o1` is read back for moves, swaps and read-outs, and read-out data is returned on a result port.

## Interface
Parameters:
- `DW`, 8, data width; matches the register file word.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  micro-op present on `op`.
- `op_ready`  out  1  sequencer can accept an op.
- `op`  in  16  micro-op.
  - `[15:12]` opcode.
  - `[11:9]` dst code.
  - `[8:6]` src code.
  - `[7:0]` immediate.
- `rf_i`  out  DW  register file data input `I`.
- `rf_o1sel`  out  3  register file `O1Sel`.
- `rf_funsel`  out  2  register file `FunSel`.
  - `00` clear, `01` load, `10` decrement, `11` increment.
- `rf_rsel`  out  4  R write enables; bit3 = R1 … bit0 = R4.
- `rf_tsel`  out  4  T write enables; bit3 = T1 … bit0 = T4.
- `rf_o1`  in  DW  register file `O1` (combinational read).
- `res_valid`  out  1  one-cycle pulse; `res_data` valid.
- `res_data`  out  DW  value returned by RD.
- `err`  out  1  one-cycle pulse on illegal opcode.

## Operation
- Register code, shared by dst, src and `O1Sel`:
  - `000`–`011` select T1–T4.
  - `100`–`111` select R1–R4.
- A code maps to a one-hot enable:
  - Codes `1xx` drive `rf_rsel`, `0xx` drive `rf_tsel`.
  - Bit position is 3 − code[1:0]; the other vector is 0.
- Opcodes:
  - 0 NOP.
  - 1 LDI: dst ← imm.
  - 2 CLR: dst ← 0.
  - 3 INC: dst ← dst + 1.
  - 4 DEC: dst ← dst − 1.
  - 5 MOV: dst ← src.
  - 6 RD: `res_data` ← src.
  - 7 SWAP: dst ↔ src.
  - 8–F illegal.
- Accepted op is captured into an internal op register; an internal DW-bit `hold` register holds read-back data.
- States and transitions:
  - IDLE → WR: LDI, CLR, INC, DEC.
  - IDLE → RDL: MOV, RD, SWAP.
  - IDLE → IDLE: NOP and illegal opcodes.
  - RDL → WR: MOV.
  - RDL → IDLE: RD.
  - RDL → MV: SWAP.
  - MV → WR: SWAP.
  - WR → IDLE.
- Per-state drive:
  - IDLE: all enables 0, `rf_funsel`=`01`, `rf_i`=0, `rf_o1sel`=`000`.
  - RDL: enables 0.
    - MOV/RD: `rf_o1sel`=src.
    - SWAP: `rf_o1sel`=dst.
    - `hold` ← `rf_o1` at cycle end.
  - MV (SWAP only): `rf_o1sel`=src, `rf_i`=`rf_o1`, `rf_funsel`=`01`, dst enable.
  - WR, dst enable, by opcode:
    - LDI: `rf_i`=imm, `rf_funsel`=`01`.
    - CLR: `00`.
    - INC: `11`.
    - DEC: `10`.
    - MOV: `rf_i`=`hold`, `01`.
    - SWAP: `rf_i`=`hold`, `01`, src enable instead of dst.
- RD: `res_data` is registered from `rf_o1` at the end of RDL; `res_valid` pulses the following cycle.
- Arithmetic: INC/DEC are executed by the register file and wrap modulo 2^DW (0xFF+1 = 0x00, 0x00−1 = 0xFF).
- Illegal opcode: `err` pulses the cycle after accept; no enable is ever asserted for that op.
- SWAP or MOV with dst = src is legal; the value is unchanged.

## Timing
- `op_ready` = 1 only in IDLE (registered state decode). An op is accepted on a rising edge with `op_valid` & `op_ready`.
- `op` is sampled only at accept. `op_valid` while busy is ignored; the producer holds the op until ready.
- Cycles from accept to the next possible accept:
  - NOP/illegal: 1.
  - LDI/CLR/INC/DEC: 2.
  - RD: 2.
  - MOV: 3.
  - SWAP: 4.
- Writes land in the register file at the end of the WR/MV cycle.
- Reset (synchronous, any state):
  - State → IDLE; op register, `hold` and `res_data` → 0.
  - `res_valid`, `err` → 0; `op_ready` = 1 the cycle after reset deasserts.
  - All enables 0 throughout reset.
  - Reset mid-op abandons the op; writes already landed (e.g. SWAP MV step) are not undone.

## Configuration
- `RFSEQ_SWAP_EN` defined: opcode 7 executes SWAP as above (states RDL→MV→WR).
- Not defined: the MV state is not built, and opcode 7 is illegal (`err` pulse, 1-cycle, no writes).

## Test plan
- Reset, then LDI R2 ← 0x5E (op 0x1A5E) → WR cycle drives `rf_rsel`=0100, `rf_funsel`=01, `rf_i`=0x5E; the register file's R2 reads 0x5E.
- LDI T4 ← 0xFF, then INC T4 → `rf_tsel`=0001, `rf_funsel`=11; T4 = 0x00 (wrap). DEC T4 → 0xFF.
- LDI R1 ← 0x18, MOV T2 ← R1, RD T2 → `res_valid` pulses once with `res_data`=0x18; R1 stays 0x18. MOV = 3 cycles accept to ready.
- With `RFSEQ_SWAP_EN`: R3=0x11, T1=0x22, SWAP R3,T1 → R3=0x22, T1=0x11, `op_ready` low for 3 cycles. Without the macro → `err` pulse, both registers unchanged.
- Opcode 0xC, and `op_valid` held while busy → `err` 1-cycle, no enable asserted. The busy op is taken only once `op_ready` rises.
- Assert `rst` during SWAP MV cycle → next cycle IDLE, `op_ready`=1, enables 0, `res_valid`/`err` 0; dst holds src's old value.
